seg7_counter_display: RTL and testbench

Parametrised free-running display counter for the board-level seven-segment examples.
- A prescaler divides CLK down to a step strobe.
- A DIGITS-wide up/down counter runs in hex or BCD mode, with parallel load, wrap-around carry and leading-zero blanking.
- A registered common-anode seven-segment bus is produced.
- Successor to the fixed single-digit hex counter/decoder example; sits between board switches/buttons and HEX outputs.

---
 rtl/seg7_pkg.sv | 66 ++++++
 rtl/seg7_decoder.sv | 17 +
 rtl/seg7_counter_display.sv | 191 +++++++++++++++++++
 tb/tb_seg7_counter_display.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// ----------------------------------------------------------------------------
// seg7_pkg
//   Shared definitions for the seven-segment counter display.
//   - SEG_W and the sixteen active-low glyphs (gfedcba), plus SEG_BLANK
//   - seg7_glyph(): nibble -> glyph lookup
//   - bcd_clamp():  forces a nibble into the 0..9 range
//   - count_mode_e: hex / BCD counting mode
// ----------------------------------------------------------------------------
package seg7_pkg;

    localparam int SEG_W = 7;

    // Active-low common-anode glyphs, bit order gfedcba.
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
    localparam logic [SEG_W-1:0] SEG_B     = 7'b0000011;
    localparam logic [SEG_W-1:0] SEG_C     = 7'b1000110;
    localparam logic [SEG_W-1:0] SEG_D     = 7'b0100001;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_F     = 7'b0001110;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic {
        CNT_HEX = 1'b0,
        CNT_BCD = 1'b1
    } count_mode_e;

    function automatic logic [SEG_W-1:0] seg7_glyph(input logic [3:0] nibble);
        logic [SEG_W-1:0] glyph;
        case (nibble)
            4'h0:    glyph = SEG_0;
            4'h1:    glyph = SEG_1;
            4'h2:    glyph = SEG_2;
            4'h3:    glyph = SEG_3;
            4'h4:    glyph = SEG_4;
            4'h5:    glyph = SEG_5;
            4'h6:    glyph = SEG_6;
            4'h7:    glyph = SEG_7;
            4'h8:    glyph = SEG_8;
            4'h9:    glyph = SEG_9;
            4'hA:    glyph = SEG_A;
            4'hB:    glyph = SEG_B;
            4'hC:    glyph = SEG_C;
            4'hD:    glyph = SEG_D;
            4'hE:    glyph = SEG_E;
            default: glyph = SEG_F;
        endcase
        return glyph;
    endfunction

    function automatic logic [3:0] bcd_clamp(input logic [3:0] nibble);
        return (nibble > BCD_MAX) ? BCD_MAX : nibble;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// ----------------------------------------------------------------------------
// seg7_decoder
//   Combinational nibble to active-low seven-segment glyph.
//   Ports:
//     nibble  in  4      digit value 0..F
//     seg     out SEG_W  segments gfedcba, active-low
// ----------------------------------------------------------------------------
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg
);

    assign seg = seg7_glyph(nibble);

endmodule

// File: rtl/seg7_counter_display.sv
// ----------------------------------------------------------------------------
// seg7_counter_display
//   Prescaled up/down display counter (hex or BCD) with parallel load,
//   wrap-around CARRY, leading-zero blanking and a registered common-anode
//   seven-segment bus.
//   Ports:
//     CLK       in   1          system clock, posedge
//     RST       in   1          synchronous reset, active-high
//     EN        in   1          prescaler enable (0 freezes count)
//     UP_DN     in   1          1 = up, 0 = down
//     MODE      in   1          0 = hex, 1 = BCD
//     LOAD      in   1          load LOAD_VAL this cycle
//     LOAD_VAL  in   4*DIGITS   parallel load value, digit 0 in [3:0]
//     BLANK_LZ  in   1          blank leading zero digits
//     COUNT     out  4*DIGITS   current count
//     TICK      out  1          step strobe
//     CARRY     out  1          one-cycle pulse alongside a wrapped COUNT
//     HEX       out  7*DIGITS   active-low segments, digit 0 in [6:0]
// ----------------------------------------------------------------------------
module seg7_counter_display
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 20_000_000,
    parameter int PSC_W    = 25
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      EN,
    input  logic                      UP_DN,
    input  logic                      MODE,
    input  logic                      LOAD,
    input  logic [4*DIGITS-1:0]       LOAD_VAL,
    input  logic                      BLANK_LZ,
    output logic [4*DIGITS-1:0]       COUNT,
    output logic                      TICK,
    output logic                      CARRY,
    output logic [SEG_W*DIGITS-1:0]   HEX
);

    localparam int               CW       = 4 * DIGITS;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(TICK_DIV - 1);
    localparam logic [PSC_W-1:0] PSC_ONE  = PSC_W'(1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

    logic [PSC_W-1:0]        psc;
    count_mode_e             mode_q;
    logic [CW-1:0]           count_q;
    logic                    carry_q;
    logic [SEG_W*DIGITS-1:0] hex_q;

    logic [CW-1:0]           hex_next;
    logic                    hex_wrap;
    logic [CW-1:0]           bcd_next;
    logic                    bcd_wrap;
    logic [CW-1:0]           step_next;
    logic                    step_wrap;
    logic [CW-1:0]           load_next;
    logic [DIGITS-1:0]       blank;
    logic [SEG_W-1:0]        glyph [DIGITS];
    logic [SEG_W*DIGITS-1:0] hex_d;

    assign TICK  = EN && (psc == PSC_LAST);
    assign COUNT = count_q;
    assign CARRY = carry_q;
    assign HEX   = hex_q;

    // ------------------------------------------------------------------
    // Hex step: plain binary, wrap detected on the value being left.
    // ------------------------------------------------------------------
    always_comb begin
        hex_next = UP_DN ? (count_q + CNT_ONE) : (count_q - CNT_ONE);
        hex_wrap = UP_DN ? (count_q == '1) : (count_q == '0);
    end

    // ------------------------------------------------------------------
    // BCD step: ripple a carry/borrow upward through the digits. The
    // ripple still being set after the top digit means a full wrap.
    // ------------------------------------------------------------------
    always_comb begin : bcd_step
        logic ripple;
        // NOTE: every combinational output gets a default first so that no
        // path through the loop leaves it unassigned (which would infer a latch).
        ripple   = 1'b1;
        bcd_next = count_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (ripple) begin
                if (UP_DN) begin
                    if (count_q[4*i +: 4] >= BCD_MAX) begin
                        bcd_next[4*i +: 4] = 4'd0;
                    end else begin
                        bcd_next[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                        ripple             = 1'b0;
                    end
                end else begin
                    if (count_q[4*i +: 4] == 4'd0) begin
                        bcd_next[4*i +: 4] = BCD_MAX;
                    end else begin
                        bcd_next[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                        ripple             = 1'b0;
                    end
                end
            end
        end
        bcd_wrap = ripple;
    end

    assign step_next = (mode_q == CNT_BCD) ? bcd_next : hex_next;
    assign step_wrap = (mode_q == CNT_BCD) ? bcd_wrap : hex_wrap;

    // A load only takes effect when MODE matches mode_q, so mode_q
    // decides whether out-of-range nibbles are clamped.
    always_comb begin
        load_next = LOAD_VAL;
        if (mode_q == CNT_BCD) begin
            for (int i = 0; i < DIGITS; i++) begin
                load_next[4*i +: 4] = bcd_clamp(LOAD_VAL[4*i +: 4]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Display: per-digit decode, then leading-zero blanking scanning
    // down from the top digit. Digit 0 is never blanked.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        seg7_decoder u_dec (
            .nibble (count_q[4*g +: 4]),
            .seg    (glyph[g])
        );
    end

    always_comb begin : lz_blank
        logic leading;
        leading = 1'b1;
        blank   = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            leading  = leading && (count_q[4*i +: 4] == 4'd0);
            blank[i] = BLANK_LZ && leading;
        end
    end

    always_comb begin
        hex_d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            hex_d[SEG_W*i +: SEG_W] = blank[i] ? SEG_BLANK : glyph[i];
        end
    end

    // ------------------------------------------------------------------
    // State. Priority: reset > mode change > load > step.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: the display register is reset too, so HEX shows a clean
            // "0" from the first cycle instead of random segments.
            psc     <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
            hex_q   <= {DIGITS{SEG_0}};
            mode_q  <= count_mode_e'(MODE);
        end else begin
            hex_q <= hex_d;
            if (count_mode_e'(MODE) != mode_q) begin
                // Switching radix restarts from zero; any LOAD is dropped.
                mode_q  <= count_mode_e'(MODE);
                count_q <= '0;
                psc     <= '0;
                carry_q <= 1'b0;
            end else if (LOAD) begin
                // Honoured even with EN=0; a coincident step is discarded.
                count_q <= load_next;
                psc     <= '0;
                carry_q <= 1'b0;
            end else if (EN) begin
                psc <= (psc == PSC_LAST) ? '0 : (psc + PSC_ONE);
                if (TICK) begin
                    count_q <= step_next;
                    carry_q <= step_wrap;
                end else begin
                    carry_q <= 1'b0;
                end
            end else begin
                carry_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_counter_display.sv
// ----------------------------------------------------------------------------
// tb_seg7_counter_display
//   Directed stimulus against a 4-digit, divide-by-4 instance. The driver
//   queues hand-computed expectations stamped with the cycle they apply
//   to; an independent monitor pops and compares them on the falling edge.
// ----------------------------------------------------------------------------
module tb_seg7_counter_display;

    localparam int DIGITS   = 4;
    localparam int TICK_DIV = 4;
    localparam int PSC_W    = 3;

    // Reference glyphs, active-low gfedcba.
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SF = 7'b0001110;
    localparam logic [6:0] SB = 7'b1111111;

    typedef enum logic [1:0] {K_COUNT, K_TICK, K_CARRY, K_HEX} kind_e;

    typedef struct {
        int          at_cyc;
        kind_e       kind;
        string       name;
        logic [31:0] exp;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST, EN, UP_DN, MODE, LOAD, BLANK_LZ;
    logic [15:0] LOAD_VAL;
    logic [15:0] COUNT;
    logic        TICK, CARRY;
    logic [27:0] HEX;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    seg7_counter_display #(
        .DIGITS   (DIGITS),
        .TICK_DIV (TICK_DIV),
        .PSC_W    (PSC_W)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .EN       (EN),
        .UP_DN    (UP_DN),
        .MODE     (MODE),
        .LOAD     (LOAD),
        .LOAD_VAL (LOAD_VAL),
        .BLANK_LZ (BLANK_LZ),
        .COUNT    (COUNT),
        .TICK     (TICK),
        .CARRY    (CARRY),
        .HEX      (HEX)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] hex4(input logic [6:0] d3, input logic [6:0] d2,
                                         input logic [6:0] d1, input logic [6:0] d0);
        return {4'b0000, d3, d2, d1, d0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Queue an expectation for the current cycle (checked at the next negedge).
    task automatic expect_q(input kind_e kind, input string name, input logic [31:0] exp);
        exp_t e;
        e.at_cyc = cyc;
        e.kind   = kind;
        e.name   = name;
        e.exp    = exp;
        sb.push_back(e);
    endtask

    task automatic edges(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Monitor: compares everything due this cycle against the live outputs.
    always @(negedge CLK) begin
        exp_t        e;
        logic [31:0] act;
        while (sb.size() > 0 && sb[0].at_cyc <= cyc) begin
            e = sb.pop_front();
            if (e.at_cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s missed: due cycle %0d, now %0d", e.name, e.at_cyc, cyc);
            end else begin
                case (e.kind)
                    K_COUNT: act = {16'h0, COUNT};
                    K_TICK:  act = {31'h0, TICK};
                    K_CARRY: act = {31'h0, CARRY};
                    default: act = {4'h0, HEX};
                endcase
                check(e.name, act, e.exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; EN = 1'b1; UP_DN = 1'b1; MODE = 1'b1;
        LOAD = 1'b0; LOAD_VAL = 16'h0000; BLANK_LZ = 1'b0;

        // ---- reset state ----
        edges(2);
        expect_q(K_COUNT, "rst_count", 32'h0);
        expect_q(K_TICK,  "rst_tick",  32'h0);
        expect_q(K_CARRY, "rst_carry", 32'h0);
        expect_q(K_HEX,   "rst_hex",   hex4(S0, S0, S0, S0));
        RST = 1'b0;

        // ---- BCD count up: TICK every 4th cycle, 10 steps -> 0x0010 ----
        for (int k = 1; k <= 41; k++) begin
            edges(1);
            if (k <= 8)  expect_q(K_TICK, "tick_period", (k % 4 == 3) ? 32'h1 : 32'h0);
            if (k == 39) expect_q(K_COUNT, "bcd_nine", 32'h0009);
            if (k == 40) begin
                expect_q(K_COUNT, "bcd_ten", 32'h0010);
                expect_q(K_CARRY, "bcd_ten_nocarry", 32'h0);
            end
            if (k == 41) expect_q(K_HEX, "hex_ten", hex4(S0, S0, S1, S0));
        end

        // ---- BCD up wrap 9999 -> 0000 with CARRY ----
        LOAD = 1'b1; LOAD_VAL = 16'h9999;
        edges(1);
        LOAD = 1'b0;
        expect_q(K_COUNT, "bcd_load_9999", 32'h9999);
        expect_q(K_TICK,  "load_clears_psc", 32'h0);
        edges(3);
        expect_q(K_TICK, "tick_after_load", 32'h1);
        edges(1);
        expect_q(K_COUNT, "bcd_wrap_count", 32'h0000);
        expect_q(K_CARRY, "bcd_wrap_carry", 32'h1);
        edges(1);
        expect_q(K_CARRY, "carry_one_cycle", 32'h0);
        expect_q(K_HEX,   "hex_after_wrap", hex4(S0, S0, S0, S0));

        // ---- BCD load clamp ----
        LOAD = 1'b1; LOAD_VAL = 16'h003C;
        edges(1);
        expect_q(K_COUNT, "clamp_3c", 32'h0039);
        LOAD_VAL = 16'hA3C5;
        edges(1);
        LOAD = 1'b0;
        expect_q(K_COUNT, "clamp_a3c5", 32'h9395);

        // ---- LOAD on a TICK cycle wins over a wrapping step ----
        LOAD = 1'b1; LOAD_VAL = 16'h9999;
        edges(1);
        LOAD = 1'b0;
        edges(3);
        expect_q(K_TICK, "tick_before_load", 32'h1);
        LOAD = 1'b1; LOAD_VAL = 16'h0025;
        edges(1);
        LOAD = 1'b0;
        expect_q(K_COUNT, "load_on_tick", 32'h0025);
        expect_q(K_CARRY, "load_on_tick_carry", 32'h0);
        expect_q(K_TICK,  "load_on_tick_psc", 32'h0);
        edges(2);
        expect_q(K_TICK, "no_early_tick", 32'h0);
        edges(1);
        expect_q(K_TICK, "tick_4_after_load", 32'h1);
        edges(1);
        expect_q(K_COUNT, "step_after_load", 32'h0026);

        // ---- EN=0 freezes count, gates TICK; LOAD still honoured ----
        edges(3);
        EN = 1'b0;
        expect_q(K_TICK, "tick_gated_by_en", 32'h0);
        edges(2);
        expect_q(K_COUNT, "en0_count_hold", 32'h0026);
        expect_q(K_CARRY, "en0_carry", 32'h0);
        expect_q(K_HEX,   "en0_hex_hold", hex4(S0, S0, S2, S6));
        LOAD = 1'b1; LOAD_VAL = 16'h0042;
        edges(1);
        LOAD = 1'b0;
        expect_q(K_COUNT, "en0_load", 32'h0042);
        edges(1);
        expect_q(K_TICK, "en0_psc_hold", 32'h0);
        EN = 1'b1;
        edges(3);
        expect_q(K_TICK, "tick_0x42", 32'h1);

        // ---- RST on a TICK cycle ----
        RST = 1'b1;
        edges(1);
        RST = 1'b0;
        expect_q(K_COUNT, "rst_on_tick_count", 32'h0);
        expect_q(K_TICK,  "rst_on_tick_tick", 32'h0);
        expect_q(K_CARRY, "rst_on_tick_carry", 32'h0);

        // ---- mode change clears count, ignores simultaneous LOAD ----
        LOAD = 1'b1; LOAD_VAL = 16'h0017;
        edges(1);
        expect_q(K_COUNT, "load_0x17", 32'h0017);
        MODE = 1'b0; LOAD_VAL = 16'h1234;
        edges(1);
        LOAD = 1'b0;
        expect_q(K_COUNT, "mode_change_count", 32'h0);
        expect_q(K_TICK,  "mode_change_psc", 32'h0);

        // ---- hex down wrap 0000 -> FFFF ----
        UP_DN = 1'b0; LOAD = 1'b1; LOAD_VAL = 16'h0000;
        edges(1);
        LOAD = 1'b0;
        edges(4);
        expect_q(K_COUNT, "hex_down_wrap", 32'hFFFF);
        expect_q(K_CARRY, "hex_down_carry", 32'h1);
        edges(1);
        expect_q(K_CARRY, "hex_down_carry_drop", 32'h0);
        expect_q(K_HEX,   "hex_all_f", hex4(SF, SF, SF, SF));

        // ---- hex up passes through A, wraps FFFF -> 0000 ----
        UP_DN = 1'b1; LOAD = 1'b1; LOAD_VAL = 16'h0009;
        edges(1);
        LOAD = 1'b0;
        edges(4);
        expect_q(K_COUNT, "hex_9_to_a", 32'h000A);
        edges(1);
        expect_q(K_HEX, "hex_glyph_a", hex4(S0, S0, S0, SA));
        LOAD = 1'b1; LOAD_VAL = 16'hFFFF;
        edges(1);
        LOAD = 1'b0;
        edges(4);
        expect_q(K_COUNT, "hex_up_wrap", 32'h0000);
        expect_q(K_CARRY, "hex_up_carry", 32'h1);

        // ---- BCD down: wrap from 0 and borrow across digits ----
        LOAD = 1'b1; LOAD_VAL = 16'h0555;
        edges(1);
        LOAD = 1'b0;
        expect_q(K_COUNT, "hex_load_555", 32'h0555);
        MODE = 1'b1; UP_DN = 1'b0;
        edges(1);
        expect_q(K_COUNT, "to_bcd_clears", 32'h0);
        edges(4);
        expect_q(K_COUNT, "bcd_down_wrap", 32'h9999);
        expect_q(K_CARRY, "bcd_down_carry", 32'h1);
        LOAD = 1'b1; LOAD_VAL = 16'h0100;
        edges(1);
        LOAD = 1'b0;
        edges(4);
        expect_q(K_COUNT, "bcd_borrow", 32'h0099);
        expect_q(K_CARRY, "bcd_borrow_nocarry", 32'h0);

        // ---- leading-zero blanking ----
        BLANK_LZ = 1'b1;
        LOAD = 1'b1; LOAD_VAL = 16'h0007;
        edges(1);
        LOAD = 1'b0;
        edges(1);
        expect_q(K_HEX, "blank_0007", hex4(SB, SB, SB, S7));
        LOAD = 1'b1; LOAD_VAL = 16'h0000;
        edges(1);
        LOAD = 1'b0;
        edges(1);
        expect_q(K_HEX, "blank_0000", hex4(SB, SB, SB, S0));
        LOAD = 1'b1; LOAD_VAL = 16'h0300;
        edges(1);
        LOAD = 1'b0;
        edges(1);
        expect_q(K_HEX, "blank_0300", hex4(SB, S3, S0, S0));
        BLANK_LZ = 1'b0;
        edges(1);
        expect_q(K_HEX, "unblank_0300", hex4(S0, S3, S0, S0));

        edges(2);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s never compared: due cycle %0d", e.name, e.at_cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
